itr_sequencer: RTL

//  Interrupt entry/exit sequencer between the interrupt priority handler and the
//  PC/fetch logic of the accumulator processor. Samples the handler's pending flag
//  at instruction boundaries, saves the return PC, and loads the ISR vector into the PC.

---
 rtl/itr_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/itr_sequencer.sv
// Interrupt entry/exit sequencer: saves the return PC, loads the ISR vector,
// blocks nesting while an ISR runs, restores the PC on RTI, and forces a return on watchdog expiry.
module itr_sequencer #(
    parameter int AW       = 8,
    parameter int WDOG_W   = 8,
    parameter int WDOG_MAX = 255
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          i_pending,
    input  logic [AW-1:0] isr_vec,
    input  logic [AW-1:0] pc_cur,
    input  logic          instr_done,
    input  logic          rti,
    input  logic          gie_set,
    input  logic          gie_clr,
    output logic          itr_en,
    output logic          itr_clr,
    output logic          pc_load,
    output logic [AW-1:0] pc_load_val,
    output logic          itr_ack,
    output logic          in_isr,
    output logic          isr_timeout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE    = 3'd1,
        VECTOR  = 3'd2,
        SERVICE = 3'd3,
        RETURN  = 3'd4
    } state_t;

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);

    state_t              state;
    logic                gie;
    logic                gie_next;
    logic [AW-1:0]       saved_pc;
    logic [AW-1:0]       vec_lat;
    logic [WDOG_W-1:0]   wdog;

    // Clear wins over set when both are requested in the same cycle.
    assign gie_next = gie_clr ? 1'b0 : (gie_set ? 1'b1 : gie);

    // Outputs are registered alongside the state, so each one is valid for the
    // whole cycle in which the new state is held.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= IDLE;
            gie         <= 1'b0;
            saved_pc    <= '0;
            vec_lat     <= '0;
            wdog        <= '0;
            itr_en      <= 1'b0;
            itr_clr     <= 1'b0;
            pc_load     <= 1'b0;
            pc_load_val <= '0;
            itr_ack     <= 1'b0;
            in_isr      <= 1'b0;
            isr_timeout <= 1'b0;
        end else begin
            // NOTE: strobes default low here so each one lasts exactly one cycle
            // and pc_load_val returns to zero whenever pc_load is not asserted.
            itr_en      <= 1'b0;
            itr_clr     <= 1'b0;
            pc_load     <= 1'b0;
            pc_load_val <= '0;
            itr_ack     <= 1'b0;
            gie         <= gie_next;
            if (gie_set) begin
                isr_timeout <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (i_pending && gie && instr_done) begin
                        state    <= SAVE;
                        saved_pc <= pc_cur;
                        vec_lat  <= isr_vec;
                        in_isr   <= 1'b1;
                    end else begin
                        itr_en <= gie_next;
                    end
                end
                SAVE: begin
                    state       <= VECTOR;
                    pc_load     <= 1'b1;
                    pc_load_val <= vec_lat;
                    itr_clr     <= 1'b1;
                    itr_ack     <= 1'b1;
                end
                VECTOR: begin
                    state <= SERVICE;
                    wdog  <= '0;
                end
                SERVICE: begin
                    if (wdog != '1) begin
                        wdog <= wdog + 1'b1;
                    end
                    // A genuine RTI takes precedence over a simultaneous watchdog expiry.
                    if (rti && instr_done) begin
                        state       <= RETURN;
                        pc_load     <= 1'b1;
                        pc_load_val <= saved_pc;
                    end else if (wdog == WDOG_LAST) begin
                        state       <= RETURN;
                        pc_load     <= 1'b1;
                        pc_load_val <= saved_pc;
                        isr_timeout <= 1'b1;
                    end
                end
                RETURN: begin
                    state  <= IDLE;
                    in_isr <= 1'b0;
                    itr_en <= gie_next;
                end
                default: begin
                    state  <= IDLE;
                    in_isr <= 1'b0;
                end
            endcase
        end
    end

endmodule
